butterfly_pipe: RTL
===================

# butterfly_pipe

Parametrised, fully pipelined radix-2 complex butterfly for the FFT datapath. It works in signed fixed point and accepts one butterfly per clock. A run-time mode input selects decimation-in-time (DIT) or decimation-in-frequency (DIF). A per-sample scale input applies a divide-by-2 with rounding, saturation is used on every narrowing step, and a sticky error flag records any saturation. It sits between the FFT stage memory read port and the write-back port, and replaces the four-multiplier/six-adder handshake chain with a fixed-latency stream.

## Interface
- DW, 16: data width of each real/imag component (signed, two's complement)
- TW, 16: twiddle width (signed, Q1.(TW-1); 0x8000 = -1.0 at TW=16)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- str_sig  in  1  input sample valid
- stall  in  1  freeze entire pipeline (all regs and outputs hold)
- mode  in  1  0 = DIT, 1 = DIF (sampled with data)
- scale  in  1  1 = halve add/sub results with rounding (sampled with data)
- clr_err  in  1  clear sticky error
- real_x0, imag_x0, real_x1, imag_x1  in  DW each  operands
- real_w, imag_w  in  TW each  twiddle
- real_y0, imag_y0, real_y1, imag_y1  out  DW each  results
- done_sig  out  1  output valid
- error  out  1  sticky saturation flag

## Operation
- Functions:
  - DIT: t = W·x1; y0 = x0 + t; y1 = x0 − t.
  - DIF: y0 = x0 + x1; y1 = (x0 − x1)·W.
- Complex multiply:
  - re = a·c − b·d; im = a·d + b·c, with full-width products.
  - Sum held at DW+TW+1 bits.
  - Result = (sum + 2^(TW-2)) >>> (TW-1), round half up, then saturated to DW.
- Add/sub:
  - Computed at DW+1 bits.
  - scale=1: (s + 1) >>> 1, which always fits in DW.
  - scale=0: saturate to DW (+2^(DW-1)-1 / −2^(DW-1)).
  - In DIF, scaling/saturation applies before the multiply.
- Pipeline stages:
  - S1: register operands, mode, scale, valid.
  - S2: DIT forms the four products; DIF forms sum/diff with scale/sat.
  - S3: DIT combines, rounds and saturates t; DIF forms the four products of diff·W.
  - S4: DIT does add/sub with scale/sat; DIF combines, rounds and saturates y1, and y0 is the delayed sum.
- mode and scale travel with each sample, so mixed-mode back-to-back streams are legal.
- A saturation event is counted only when its stage holds valid data.
- error:
  - Set by any saturation event on any component.
  - Cleared by clr_err.
  - If set and clear occur in the same cycle, set wins.
- Corner case: multiplying (−2^(DW-1)) by W = −1.0 saturates and sets error.

## Timing
- Reset (async assert, sync deassert handled upstream): all pipeline registers, all y outputs, done_sig and error go to 0.
- Latency:
  - A sample is accepted on an edge with str_sig=1 and stall=0.
  - Its results and done_sig=1 appear after the 4th subsequent non-stalled edge.
  - Throughput is one sample per cycle.
- stall=1:
  - No register updates, and str_sig is ignored.
  - done_sig and the y outputs hold their values.
  - No sample is dropped or duplicated.
  - clr_err still acts during stall.
- done_sig is high for exactly one non-stalled cycle per accepted sample.
- y outputs are don't-care when done_sig=0, but must not change while stalled.
- Reset mid-stream discards all in-flight samples. No done_sig is produced after release until new input arrives.

## Test plan
- DIT basic (DW=TW=16), scale=0:
  - Stimulus: x0=(1000,0), x1=(0,2000), W=(0,0x8000).
  - Required: y0=(3000,0), y1=(−1000,0), done_sig exactly 4 cycles after str_sig, error=0.
- DIF basic:
  - Stimulus: x0=(100,−50), x1=(20,30), W=(0,0x8000).
  - Required: y0=(120,−20), y1=(−80,−80).
- Saturation and scaling:
  - DIT, x0=(30000,0), x1=(10000,0), W=(0x7FFF,0), scale=0 → y0=(32767,0), y1=(20000,0), error=1.
  - Same with scale=1 after clr_err → y0=(20000,0), y1=(10000,0), error stays 0.
- Stream and stall:
  - Stimulus: 8 back-to-back samples with alternating mode; stall high for 2 cycles while the pipeline is full.
  - Required: 8 done_sig pulses in order with values matching the model, outputs frozen during the stall, no gaps other than the stall.
- Reset mid-operation:
  - Stimulus: rst_n low for 1 cycle with 3 samples in flight.
  - Required: all outputs 0 immediately, no done_sig in the 10 cycles after release without new input.
- Error priority:
  - Stimulus: clr_err asserted in the same cycle as a saturating sample reaches its saturation stage.
  - Required: error=1. A later clr_err alone clears it to 0.

Source files
------------

// File: rtl/butterfly_pipe.sv
// butterfly_pipe
//   Fully pipelined radix-2 complex butterfly, one butterfly per clock.
//   mode_i selects DIT (t = W*x1, y0 = x0 + t, y1 = x0 - t) or
//   DIF (y0 = x0 + x1, y1 = (x0 - x1)*W). mode_i and scale_i travel with
//   each sample. Every narrowing step saturates, and any saturation on a
//   valid sample sets the sticky error_o flag.
//
// Ports
//   clk_i, rst_n_i                    clock, async active-low reset
//   str_sig_i                         input sample valid
//   stall_i                           freeze the whole pipeline
//   mode_i                            0 = DIT, 1 = DIF
//   scale_i                           halve add/sub results with rounding
//   clr_err_i                         clear sticky error (set wins)
//   real/imag_x0_i, real/imag_x1_i    operands, signed DW
//   real/imag_w_i                     twiddle, signed Q1.(TW-1)
//   real/imag_y0_o, real/imag_y1_o    results, signed DW
//   done_sig_o                        result valid, 4 edges after accept
//   error_o                           sticky saturation flag
//
// Stages: S1 operand capture, S2 DIT products / DIF sum+diff,
//         S3 DIT t = W*x1 / DIF products of diff*W, S4 output registers.
module butterfly_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          str_sig_i,
  input  logic          stall_i,
  input  logic          mode_i,
  input  logic          scale_i,
  input  logic          clr_err_i,
  input  logic [DW-1:0] real_x0_i,
  input  logic [DW-1:0] imag_x0_i,
  input  logic [DW-1:0] real_x1_i,
  input  logic [DW-1:0] imag_x1_i,
  input  logic [TW-1:0] real_w_i,
  input  logic [TW-1:0] imag_w_i,
  output logic [DW-1:0] real_y0_o,
  output logic [DW-1:0] imag_y0_o,
  output logic [DW-1:0] real_y1_o,
  output logic [DW-1:0] imag_y1_o,
  output logic          done_sig_o,
  output logic          error_o
);

  localparam int PW = DW + TW;      // full product width
  localparam int SW = DW + TW + 1;  // product sum width

  localparam logic signed [DW+1:0] A_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] A_MIN = {3'b111, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] M_MAX = {{(TW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] M_MIN = {{(TW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] M_RND = {{(DW+2){1'b0}}, 1'b1, {(TW-2){1'b0}}};

  // Returns {saturated, result}. Halving with rounding always fits in DW,
  // so it never reports saturation.
  function automatic logic [DW:0] addsub(input logic signed [DW-1:0] a,
                                         input logic signed [DW-1:0] b,
                                         input logic sub,
                                         input logic scl);
    logic signed [DW+1:0] s;
    logic signed [DW+1:0] r;
    logic                 sat;
    s   = sub ? ((DW+2)'(a) - (DW+2)'(b)) : ((DW+2)'(a) + (DW+2)'(b));
    r   = s;
    sat = 1'b0;
    if (scl) begin
      r = (s + (DW+2)'(1)) >>> 1;
    end else if (s > A_MAX) begin
      r   = A_MAX;
      sat = 1'b1;
    end else if (s < A_MIN) begin
      r   = A_MIN;
      sat = 1'b1;
    end
    return {sat, r[DW-1:0]};
  endfunction

  // One component of a complex product: (p -/+ q), round half up, saturate.
  function automatic logic [DW:0] cplx_part(input logic signed [PW-1:0] p,
                                            input logic signed [PW-1:0] q,
                                            input logic sub);
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] r;
    logic                 sat;
    s   = sub ? (SW'(p) - SW'(q)) : (SW'(p) + SW'(q));
    r   = (s + M_RND) >>> (TW-1);
    sat = 1'b0;
    if (r > M_MAX) begin
      r   = M_MAX;
      sat = 1'b1;
    end else if (r < M_MIN) begin
      r   = M_MIN;
      sat = 1'b1;
    end
    return {sat, r[DW-1:0]};
  endfunction

  // S1
  logic                 s1_v_q, s1_mode_q, s1_scale_q;
  logic signed [DW-1:0] s1_x0r_q, s1_x0i_q, s1_x1r_q, s1_x1i_q;
  logic signed [TW-1:0] s1_wr_q, s1_wi_q;
  // S2
  logic                 s2_v_q, s2_mode_q, s2_scale_q;
  logic signed [PW-1:0] s2_ac_q, s2_bd_q, s2_ad_q, s2_bc_q;
  logic signed [DW-1:0] s2_ar_q, s2_ai_q, s2_dr_q, s2_di_q;
  logic signed [TW-1:0] s2_wr_q, s2_wi_q;
  // S3
  logic                 s3_v_q, s3_mode_q, s3_scale_q;
  logic signed [PW-1:0] s3_ac_q, s3_bd_q, s3_ad_q, s3_bc_q;
  logic signed [DW-1:0] s3_ar_q, s3_ai_q, s3_tr_q, s3_ti_q;
  // S4 / outputs
  logic signed [DW-1:0] y0r_q, y0i_q, y1r_q, y1i_q;
  logic                 done_q, err_q;

  logic [DW:0] sum_r, sum_i, dif_r, dif_i;
  logic [DW:0] t_r, t_i;
  logic [DW:0] u0_r, u0_i, u1_r, u1_i, v_r, v_i;

  logic signed [PW-1:0] s2_ac_d, s2_bd_d, s2_ad_d, s2_bc_d;
  logic signed [PW-1:0] s3_ac_d, s3_bd_d, s3_ad_d, s3_bc_d;
  logic signed [DW-1:0] s2_ar_d, s2_ai_d;
  logic signed [DW-1:0] y0r_d, y0i_d, y1r_d, y1i_d;
  logic                 sat_s2, sat_s3, sat_s4, err_d;

  // S2 next state: DIF sum/diff (x0 rides along for DIT), DIT products x1*W
  assign sum_r = addsub(s1_x0r_q, s1_x1r_q, 1'b0, s1_scale_q);
  assign sum_i = addsub(s1_x0i_q, s1_x1i_q, 1'b0, s1_scale_q);
  assign dif_r = addsub(s1_x0r_q, s1_x1r_q, 1'b1, s1_scale_q);
  assign dif_i = addsub(s1_x0i_q, s1_x1i_q, 1'b1, s1_scale_q);

  assign s2_ar_d = s1_mode_q ? $signed(sum_r[DW-1:0]) : s1_x0r_q;
  assign s2_ai_d = s1_mode_q ? $signed(sum_i[DW-1:0]) : s1_x0i_q;

  assign s2_ac_d = PW'(s1_x1r_q) * PW'(s1_wr_q);
  assign s2_bd_d = PW'(s1_x1i_q) * PW'(s1_wi_q);
  assign s2_ad_d = PW'(s1_x1r_q) * PW'(s1_wi_q);
  assign s2_bc_d = PW'(s1_x1i_q) * PW'(s1_wr_q);

  // S3 next state: DIT t = x1*W, DIF products of diff*W
  assign t_r = cplx_part(s2_ac_q, s2_bd_q, 1'b1);
  assign t_i = cplx_part(s2_ad_q, s2_bc_q, 1'b0);

  assign s3_ac_d = PW'(s2_dr_q) * PW'(s2_wr_q);
  assign s3_bd_d = PW'(s2_di_q) * PW'(s2_wi_q);
  assign s3_ad_d = PW'(s2_dr_q) * PW'(s2_wi_q);
  assign s3_bc_d = PW'(s2_di_q) * PW'(s2_wr_q);

  // S4 next state: DIT add/sub with t, DIF y1 combine; DIF y0 is the held sum
  assign u0_r = addsub(s3_ar_q, s3_tr_q, 1'b0, s3_scale_q);
  assign u0_i = addsub(s3_ai_q, s3_ti_q, 1'b0, s3_scale_q);
  assign u1_r = addsub(s3_ar_q, s3_tr_q, 1'b1, s3_scale_q);
  assign u1_i = addsub(s3_ai_q, s3_ti_q, 1'b1, s3_scale_q);
  assign v_r  = cplx_part(s3_ac_q, s3_bd_q, 1'b1);
  assign v_i  = cplx_part(s3_ad_q, s3_bc_q, 1'b0);

  assign y0r_d = s3_mode_q ? s3_ar_q : $signed(u0_r[DW-1:0]);
  assign y0i_d = s3_mode_q ? s3_ai_q : $signed(u0_i[DW-1:0]);
  assign y1r_d = s3_mode_q ? $signed(v_r[DW-1:0]) : $signed(u1_r[DW-1:0]);
  assign y1i_d = s3_mode_q ? $signed(v_i[DW-1:0]) : $signed(u1_i[DW-1:0]);

  // Saturation only counts for the mode that actually uses that stage's result
  assign sat_s2 = s1_v_q & s1_mode_q & (sum_r[DW] | sum_i[DW] | dif_r[DW] | dif_i[DW]);
  assign sat_s3 = s2_v_q & ~s2_mode_q & (t_r[DW] | t_i[DW]);
  assign sat_s4 = s3_v_q & (s3_mode_q ? (v_r[DW] | v_i[DW])
                                      : (u0_r[DW] | u0_i[DW] | u1_r[DW] | u1_i[DW]));

  always_comb begin
    err_d = err_q;
    if (clr_err_i) err_d = 1'b0;
    if (!stall_i && (sat_s2 | sat_s3 | sat_s4)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_v_q <= 1'b0; s1_mode_q <= 1'b0; s1_scale_q <= 1'b0;
      s1_x0r_q <= '0; s1_x0i_q <= '0; s1_x1r_q <= '0; s1_x1i_q <= '0;
      s1_wr_q <= '0; s1_wi_q <= '0;
      s2_v_q <= 1'b0; s2_mode_q <= 1'b0; s2_scale_q <= 1'b0;
      s2_ac_q <= '0; s2_bd_q <= '0; s2_ad_q <= '0; s2_bc_q <= '0;
      s2_ar_q <= '0; s2_ai_q <= '0; s2_dr_q <= '0; s2_di_q <= '0;
      s2_wr_q <= '0; s2_wi_q <= '0;
      s3_v_q <= 1'b0; s3_mode_q <= 1'b0; s3_scale_q <= 1'b0;
      s3_ac_q <= '0; s3_bd_q <= '0; s3_ad_q <= '0; s3_bc_q <= '0;
      s3_ar_q <= '0; s3_ai_q <= '0; s3_tr_q <= '0; s3_ti_q <= '0;
      y0r_q <= '0; y0i_q <= '0; y1r_q <= '0; y1i_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (!stall_i) begin
        s1_v_q     <= str_sig_i;
        s1_mode_q  <= mode_i;
        s1_scale_q <= scale_i;
        s1_x0r_q   <= $signed(real_x0_i);
        s1_x0i_q   <= $signed(imag_x0_i);
        s1_x1r_q   <= $signed(real_x1_i);
        s1_x1i_q   <= $signed(imag_x1_i);
        s1_wr_q    <= $signed(real_w_i);
        s1_wi_q    <= $signed(imag_w_i);

        s2_v_q     <= s1_v_q;
        s2_mode_q  <= s1_mode_q;
        s2_scale_q <= s1_scale_q;
        s2_ac_q    <= s2_ac_d;
        s2_bd_q    <= s2_bd_d;
        s2_ad_q    <= s2_ad_d;
        s2_bc_q    <= s2_bc_d;
        s2_ar_q    <= s2_ar_d;
        s2_ai_q    <= s2_ai_d;
        s2_dr_q    <= $signed(dif_r[DW-1:0]);
        s2_di_q    <= $signed(dif_i[DW-1:0]);
        s2_wr_q    <= s1_wr_q;
        s2_wi_q    <= s1_wi_q;

        s3_v_q     <= s2_v_q;
        s3_mode_q  <= s2_mode_q;
        s3_scale_q <= s2_scale_q;
        s3_ac_q    <= s3_ac_d;
        s3_bd_q    <= s3_bd_d;
        s3_ad_q    <= s3_ad_d;
        s3_bc_q    <= s3_bc_d;
        s3_ar_q    <= s2_ar_q;
        s3_ai_q    <= s2_ai_q;
        s3_tr_q    <= $signed(t_r[DW-1:0]);
        s3_ti_q    <= $signed(t_i[DW-1:0]);

        done_q <= s3_v_q;
        if (s3_v_q) begin
          y0r_q <= y0r_d;
          y0i_q <= y0i_d;
          y1r_q <= y1r_d;
          y1i_q <= y1i_d;
        end
      end
    end
  end

  assign real_y0_o  = y0r_q;
  assign imag_y0_o  = y0i_q;
  assign real_y1_o  = y1r_q;
  assign imag_y1_o  = y1i_q;
  assign done_sig_o = done_q;
  assign error_o    = err_q;

endmodule
